// File: rtl/updown_counter.sv
// Parametrised up/down counter with modulus, enable prescaler, parallel load and wrap/saturate mode.
// Latency: count/tick/wrap update on the same rising edge as the step, load or reset; tc is combinational from count and up.
// Backpressure: none; en gates progress, and prescaler phase and count hold while en is low.
module updown_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             tc
);

    // Prescaler needs to hold 0..PRESCALE-1; one spare bit keeps PRESCALE=1 legal.
    localparam int unsigned PW = $clog2(PRESCALE) + 1;

    // Highest legal count value; MODULUS may equal 2**WIDTH, so compute in 64 bits.
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 64'd1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic             step;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_clamped;

    // A step happens on the enabled edge where the prescaler completes its period.
    assign step   = en && (pre == PRE_LAST);
    assign at_top = (count == MAX_CNT);
    assign at_bot = (count == '0);

    // Out-of-range load values pin to the top of the range rather than aliasing.
    assign load_clamped = (64'(load_val) >= MODULUS) ? MAX_CNT : load_val;

    // Terminal count looks at the end of the range in the current direction.
    assign tc = up ? at_top : at_bot;

    // Counter, prescaler and status pulses: rst > load > step > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            pre   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            pre   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (en) begin
            tick <= step;
            wrap <= 1'b0;
            if (step) begin
                pre <= '0;
                // Range-end compare comes before the add so count never leaves 0..MODULUS-1.
                if (up) begin
                    if (!at_top) begin
                        count <= count + WIDTH'(1);
                    end else if (!sat) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end
                end else begin
                    if (!at_bot) begin
                        count <= count - WIDTH'(1);
                    end else if (!sat) begin
                        count <= MAX_CNT;
                        wrap  <= 1'b1;
                    end
                end
            end else begin
                pre <= pre + PW'(1);
            end
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (mod 16, mod 10, prescale 3) share one stimulus stream.
// Each edge is checked against an arithmetic reference model of every instance.
// Directed scenarios first, then a randomized stretch.
module tb_updown_counter;

    localparam int N = 3;
    localparam int MODS [N] = '{16, 10, 16};
    localparam int PRES [N] = '{1, 1, 3};

    logic       clk = 1'b0;
    logic       rst, en, up, sat, load;
    logic [3:0] load_val;

    logic [3:0] cnt_o  [N];
    logic       tick_o [N];
    logic       wrap_o [N];
    logic       tc_o   [N];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cnt  [N];
    int m_pre  [N];
    int m_tick [N];
    int m_wrap [N];

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_m16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
        .count(cnt_o[0]), .tick(tick_o[0]), .wrap(wrap_o[0]), .tc(tc_o[0])
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
        .count(cnt_o[1]), .tick(tick_o[1]), .wrap(wrap_o[1]), .tc(tc_o[1])
    );

    updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_p3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
        .count(cnt_o[2]), .tick(tick_o[2]), .wrap(wrap_o[2]), .tc(tc_o[2])
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    // Advance the model one edge using the plain rules: count lives in 0..mod-1,
    // a step moves by +/-1, leaving the range either wraps modulo mod or is refused.
    task automatic model_edge(input int r, input int e, input int u, input int s, input int l, input int lv);
        int nxt;
        for (int i = 0; i < N; i++) begin
            m_tick[i] = 0;
            m_wrap[i] = 0;
            if (r != 0) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (l != 0) begin
                m_cnt[i] = (lv >= MODS[i]) ? MODS[i] - 1 : lv;
                m_pre[i] = 0;
            end else if (e != 0) begin
                m_pre[i] = m_pre[i] + 1;
                if (m_pre[i] == PRES[i]) begin
                    m_pre[i]  = 0;
                    m_tick[i] = 1;
                    nxt = (u != 0) ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    if (nxt < 0 || nxt >= MODS[i]) begin
                        if (s == 0) begin
                            m_cnt[i]  = (nxt + MODS[i]) % MODS[i];
                            m_wrap[i] = 1;
                        end
                    end else begin
                        m_cnt[i] = nxt;
                    end
                end
            end
        end
    endtask

    // Apply inputs, take one rising edge, then compare every output just after it.
    task automatic drive(input int r, input int e, input int u, input int s, input int l, input int lv);
        int exp_tc;
        rst      = (r != 0);
        en       = (e != 0);
        up       = (u != 0);
        sat      = (s != 0);
        load     = (l != 0);
        load_val = 4'(lv);
        @(posedge clk);
        model_edge(r, e, u, s, l, lv);
        #1;
        for (int i = 0; i < N; i++) begin
            exp_tc = (u != 0) ? int'(m_cnt[i] == MODS[i] - 1) : int'(m_cnt[i] == 0);
            chk("count", i, 32'(cnt_o[i]), 32'(m_cnt[i]));
            chk("tick",  i, 32'(tick_o[i]), 32'(m_tick[i]));
            chk("wrap",  i, 32'(wrap_o[i]), 32'(m_wrap[i]));
            chk("tc",    i, 32'(tc_o[i]),   32'(exp_tc));
        end
    endtask

    initial begin
        int ru, rs;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
        end

        // Reset for two cycles, then check the reset state directly.
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        chk("rst_count", 0, 32'(cnt_o[0]), 32'd0);
        chk("rst_tc_up", 0, 32'(tc_o[0]), 32'd0);

        // Free count up: first edge must already show 1; 16 steps wrap back to 0.
        drive(0, 1, 1, 0, 0, 0);
        chk("first_step", 0, 32'(cnt_o[0]), 32'd1);
        chk("first_tick", 0, 32'(tick_o[0]), 32'd1);
        for (int k = 0; k < 15; k++) drive(0, 1, 1, 0, 0, 0);
        chk("wrap16_cnt", 0, 32'(cnt_o[0]), 32'd0);
        chk("wrap16_pls", 0, 32'(wrap_o[0]), 32'd1);
        drive(0, 1, 1, 0, 0, 0);
        chk("wrap16_one", 0, 32'(wrap_o[0]), 32'd0);

        // Mod 10: load 8, count to 9 (tc), then wrap to 0.
        drive(0, 0, 1, 0, 1, 8);
        drive(0, 1, 1, 0, 0, 0);
        chk("m10_nine", 1, 32'(cnt_o[1]), 32'd9);
        chk("m10_tc",   1, 32'(tc_o[1]), 32'd1);
        drive(0, 1, 1, 0, 0, 0);
        chk("m10_wrap", 1, 32'(wrap_o[1]), 32'd1);
        chk("m10_zero", 1, 32'(cnt_o[1]), 32'd0);

        // Saturating: stays at 9 with tick but no wrap.
        drive(0, 0, 1, 1, 1, 8);
        drive(0, 1, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        chk("sat_hold", 1, 32'(cnt_o[1]), 32'd9);
        chk("sat_tick", 1, 32'(tick_o[1]), 32'd1);
        chk("sat_nowr", 1, 32'(wrap_o[1]), 32'd0);

        // Clamp of an out-of-range load value.
        drive(0, 0, 1, 1, 1, 12);
        chk("clamp", 1, 32'(cnt_o[1]), 32'd9);

        // Count down from reset, wrap mode then saturate mode.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        chk("down_wrap", 1, 32'(cnt_o[1]), 32'd9);
        drive(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 1, 0, 0);
        chk("down_sat", 1, 32'(cnt_o[1]), 32'd0);
        chk("down_tc",  1, 32'(tc_o[1]), 32'd1);

        // Prescale 3: steps on edges 3 and 8 with en dropped after edge 4.
        drive(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("p3_edge7", 2, 32'(tick_o[2]), 32'd0);
        drive(0, 1, 1, 0, 0, 0);
        chk("p3_edge8", 2, 32'(tick_o[2]), 32'd1);
        chk("p3_cnt8",  2, 32'(cnt_o[2]), 32'd2);

        // Reset overrides a coincident load.
        drive(1, 1, 1, 0, 1, 5);
        chk("rst_over_ld", 2, 32'(cnt_o[2]), 32'd0);

        // Load coincident with a terminal step wins and restarts the prescaler.
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 5);
        chk("ld_step_cnt",  2, 32'(cnt_o[2]), 32'd5);
        chk("ld_step_tick", 2, 32'(tick_o[2]), 32'd0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("ld_full_per", 2, 32'(cnt_o[2]), 32'd6);

        // Mid-operation reset at count 7 with prescaler phase 1.
        drive(0, 0, 1, 0, 1, 7);
        drive(0, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        chk("mid_rst_cnt",  2, 32'(cnt_o[2]), 32'd0);
        chk("mid_rst_tick", 2, 32'(tick_o[2]), 32'd0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("mid_rst_step", 2, 32'(cnt_o[2]), 32'd1);

        // Randomized traffic: rare resets, occasional loads, sticky direction/mode.
        ru = 1;
        rs = 0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) ru = int'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rs = int'($urandom_range(0, 1));
            drive(int'($urandom_range(0, 59) == 0),
                  int'($urandom_range(0, 3) != 0),
                  ru, rs,
                  int'($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
